// File: rtl/bsg_halfpod_seq_pkg.sv
// Shared types and constants for the halfpod link reset sequencer.
package bsg_halfpod_seq_pkg;

  // Number of timed phases between IDLE and DONE (ENABLE..DOWNSTREAM).
  localparam int unsigned num_phases_lp = 6;

  typedef enum logic [2:0] {
    e_idle       = 3'd0,
    e_enable     = 3'd1,
    e_token      = 3'd2,
    e_settle     = 3'd3,
    e_uplink     = 3'd4,
    e_downlink   = 3'd5,
    e_downstream = 3'd6,
    e_done       = 3'd7
  } bsg_halfpod_seq_state_e;

  // Successor of a timed phase; DOWNSTREAM hands over to DONE.
  function automatic bsg_halfpod_seq_state_e next_phase_f(input bsg_halfpod_seq_state_e s);
    bsg_halfpod_seq_state_e n;
    n = e_idle;
    case (s)
      e_enable:     n = e_token;
      e_token:      n = e_settle;
      e_settle:     n = e_uplink;
      e_uplink:     n = e_downlink;
      e_downlink:   n = e_downstream;
      e_downstream: n = e_done;
      default:      n = e_idle;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bsg_halfpod_hold_timer.sv
// Loadable down-counter that parks at zero; zero_o marks the last cycle of a phase.
module bsg_halfpod_hold_timer #(
  parameter int hold_width_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic [hold_width_p-1:0] load_val_i,
  output logic                    zero_o
);

  logic [hold_width_p-1:0] count_q, count_d;

  // Clear beats load; otherwise count down and stop at zero.
  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (load_i)
      count_d = load_val_i;
    else if (count_q != '0)
      count_d = count_q - hold_width_p'(1);
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/bsg_halfpod_link_reset_sequencer.sv
// Ordered, timed bring-up of the halfpod SDR links and core from a single start command.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  IDLE       | everything held in reset, ready for start
//  ENABLE     | link pads enabled
//  TOKEN      | token reset pulse asserted
//  SETTLE     | token reset dropped, waiting for tokens to settle
//  UPLINK     | uplink reset released
//  DOWNLINK   | downlink reset released
//  DOWNSTREAM | downstream reset released
//  DONE       | core reset released, done asserted until abort
module bsg_halfpod_link_reset_sequencer
  import bsg_halfpod_seq_pkg::*;
#(
  parameter int num_links_p  = 3,
  parameter int hold_width_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    start_v_i,
  output logic                    start_ready_o,
  input  logic                    abort_i,
  input  logic [num_links_p-1:0]  link_mask_i,
  input  logic [hold_width_p-1:0] hold_cycles_i,
  output logic [num_links_p-1:0]  link_disable_o,
  output logic [num_links_p-1:0]  token_reset_o,
  output logic [num_links_p-1:0]  uplink_reset_o,
  output logic [num_links_p-1:0]  downlink_reset_o,
  output logic [num_links_p-1:0]  downstream_reset_o,
  output logic                    core_reset_o,
  output logic                    done_o,
  output logic                    err_o
);

  bsg_halfpod_seq_state_e  state_q, state_d;
  logic [num_links_p-1:0]  mask_q, mask_d;
  logic [hold_width_p-1:0] hold_m1_q, hold_m1_d;
  logic                    err_q, err_d;

  logic                    timer_clear, timer_load, timer_zero;
  logic [hold_width_p-1:0] timer_val;
  logic [hold_width_p-1:0] hold_eff_m1;

  // A hold of zero behaves as one cycle per phase.
  assign hold_eff_m1 = (hold_cycles_i == '0) ? '0 : hold_cycles_i - hold_width_p'(1);

  bsg_halfpod_hold_timer #(.hold_width_p(hold_width_p)) timer (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .clear_i    (timer_clear),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .zero_o     (timer_zero)
  );

  // State, latched configuration and error pulse registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= e_idle;
      mask_q    <= '0;
      hold_m1_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      hold_m1_q <= hold_m1_d;
      err_q     <= err_d;
    end
  end

  // Next-state: accept start in IDLE, step timed phases on timer expiry, abort to IDLE.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    hold_m1_d   = hold_m1_q;
    err_d       = 1'b0;
    timer_clear = 1'b0;
    timer_load  = 1'b0;
    timer_val   = hold_m1_q;
    case (state_q)
      e_idle: begin
        // Abort in the same cycle blocks the start.
        if (start_v_i && !abort_i) begin
          if (link_mask_i == '0) begin
            err_d = 1'b1;
          end else begin
            state_d    = e_enable;
            mask_d     = link_mask_i;
            hold_m1_d  = hold_eff_m1;
            timer_load = 1'b1;
            timer_val  = hold_eff_m1;
          end
        end
      end
      e_done: begin
        if (abort_i) begin
          state_d     = e_idle;
          mask_d      = '0;
          timer_clear = 1'b1;
        end
      end
      default: begin
        if (abort_i) begin
          state_d     = e_idle;
          mask_d      = '0;
          timer_clear = 1'b1;
        end else if (timer_zero) begin
          state_d    = next_phase_f(state_q);
          timer_load = 1'b1;
        end
      end
    endcase
  end

  logic en_s, tok_s, up_rel_s, dn_rel_s, ds_rel_s;

  // Output decode from state and latched mask; releases accumulate through DONE.
  always_comb begin
    en_s     = (state_q != e_idle);
    tok_s    = (state_q == e_token);
    up_rel_s = (state_q inside {e_uplink, e_downlink, e_downstream, e_done});
    dn_rel_s = (state_q inside {e_downlink, e_downstream, e_done});
    ds_rel_s = (state_q inside {e_downstream, e_done});

    link_disable_o     = ~({num_links_p{en_s}}     & mask_q);
    token_reset_o      =   {num_links_p{tok_s}}    & mask_q;
    uplink_reset_o     = ~({num_links_p{up_rel_s}} & mask_q);
    downlink_reset_o   = ~({num_links_p{dn_rel_s}} & mask_q);
    downstream_reset_o = ~({num_links_p{ds_rel_s}} & mask_q);
    core_reset_o       = (state_q != e_done);
    done_o             = (state_q == e_done);
    start_ready_o      = (state_q == e_idle);
    err_o              = err_q;
  end

endmodule
